// File: rtl/ct_f_spsram_256x59_ctrl.sv
// Access controller for a single-port 256x59 SRAM: clears every entry after reset or on
// request, then serves read/write requests and returns read data with back-pressure.
module ct_f_spsram_256x59_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 59,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_start,
    output logic                  init_done,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    // The macro only honours WEN per partition {top bit}, {middle}, {low}.
    localparam int LO_W  = (DATA_WIDTH - 1) / 2;
    localparam int MID_W = DATA_WIDTH - 1 - LO_W;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        ST_RST,
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  init_pend_q, init_pend_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic                  rsp_stall;
    logic                  accept;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        init_pend_d = init_pend_q;
        rsp_vld_d   = rsp_vld_q;
        req_rdy     = 1'b0;
        accept      = 1'b0;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_wen    = '1;
        sram_a      = '0;
        sram_d      = '0;
        rsp_stall   = rsp_vld_q & ~rsp_rdy;

        case (state_q)
            ST_RST: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
            ST_INIT: begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = cnt_q;
                sram_d    = INIT_VALUE;
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                req_rdy = ~init_pend_q & ~init_start & ~rsp_stall;
                accept  = req_vld & req_rdy;
                if (accept) begin
                    sram_cen = 1'b0;
                    sram_a   = req_addr;
                    if (req_wr) begin
                        sram_gwen = 1'b0;
                        sram_d    = req_wdata;
                        sram_wen  = ~{req_wmask[DATA_WIDTH-1],
                                      {MID_W{req_wmask[DATA_WIDTH-2]}},
                                      {LO_W{req_wmask[LO_W-1]}}};
                    end
                end
                if (accept & ~req_wr) begin
                    rsp_vld_d = 1'b1;
                end else if (rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                end
                // A new sweep must not start while a response is still owed to the consumer.
                if ((init_start | init_pend_q) & ~rsp_stall) begin
                    state_d     = ST_INIT;
                    cnt_d       = '0;
                    init_pend_d = 1'b0;
                    init_done_d = 1'b0;
                end else if (init_start) begin
                    init_pend_d = 1'b1;
                end
            end
            default: state_d = ST_RST;
        endcase

        // Hold the SRAM idle for the whole time reset is asserted, not just after the next edge.
        if (!cpurst_b) begin
            req_rdy   = 1'b0;
            sram_cen  = 1'b1;
            sram_gwen = 1'b1;
            sram_wen  = '1;
            sram_a    = '0;
            sram_d    = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q     <= ST_RST;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            init_pend_q <= 1'b0;
            rsp_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            init_pend_q <= init_pend_d;
            rsp_vld_q   <= rsp_vld_d;
        end
    end

    assign init_done = init_done_q;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_rdata = sram_q;

endmodule

// File: tb/tb_ct_f_spsram_256x59_ctrl.sv
// Directed self-checking bench for ct_f_spsram_256x59_ctrl with a behavioural 256x59 SRAM
// (per-bit WEN, Q held while CEN is high).
module tb_ct_f_spsram_256x59_ctrl;

    logic        clk = 1'b0;
    logic        cpurst_b;
    logic        init_start;
    logic        init_done;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [58:0] req_wdata;
    logic [58:0] req_wmask;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [58:0] rsp_rdata;
    logic [7:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [58:0] sram_wen;
    logic [58:0] sram_d;
    logic [58:0] sram_q;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [58:0] D1   = 59'h5A5A5A5A5A5A5A5;
    localparam logic [58:0] D2   = 59'h123456789ABCDEF;
    // D1 with bits [57:29] forced to 1 by the partial write.
    localparam logic [58:0] EXP3 = D1 | {1'b0, {29{1'b1}}, 29'd0};

    always #5 clk = ~clk;

    ct_f_spsram_256x59_ctrl dut (
        .forever_cpuclk(clk),
        .cpurst_b      (cpurst_b),
        .init_start    (init_start),
        .init_done     (init_done),
        .req_vld       (req_vld),
        .req_rdy       (req_rdy),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wmask     (req_wmask),
        .rsp_vld       (rsp_vld),
        .rsp_rdy       (rsp_rdy),
        .rsp_rdata     (rsp_rdata),
        .sram_a        (sram_a),
        .sram_cen      (sram_cen),
        .sram_gwen     (sram_gwen),
        .sram_wen      (sram_wen),
        .sram_d        (sram_d),
        .sram_q        (sram_q)
    );

    // Behavioural SRAM, preloaded with garbage so the clear sweep is actually observable.
    logic [58:0] mem [256];
    initial begin
        sram_q = '0;
        for (int i = 0; i < 256; i++) mem[i] = 59'h7F0F0F0F0F0F0F0 ^ 59'(i);
    end
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q      <= mem[sram_a];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (init_done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check(tag, 64'(init_done), 64'd1);
    endtask

    task automatic wait_addr(input string tag, input logic [7:0] addr);
        int n = 0;
        while (sram_a !== addr && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(sram_a), 64'(addr));
    endtask

    task automatic do_write(input string tag, input logic [7:0] addr,
                            input logic [58:0] data, input logic [58:0] mask);
        req_vld = 1'b1; req_wr = 1'b1; req_addr = addr; req_wdata = data; req_wmask = mask;
        #1;
        check({tag, "_rdy"}, 64'(req_rdy), 64'd1);
        tick();
        req_vld = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [7:0] addr, input logic [58:0] exp);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = addr;
        #1;
        check({tag, "_rdy"}, 64'(req_rdy), 64'd1);
        tick();
        req_vld = 1'b0;
        check({tag, "_vld"}, 64'(rsp_vld), 64'd1);
        check({tag, "_data"}, 64'(rsp_rdata), 64'(exp));
    endtask

    initial begin
        int n;
        int strobes;
        bit seq_ok;

        cpurst_b = 1'b0; init_start = 1'b0; req_vld = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_rsp_vld",   64'(rsp_vld),   64'd0);
        check("rst_req_rdy",   64'(req_rdy),   64'd0);
        check("rst_cen",       64'(sram_cen),  64'd1);
        check("rst_gwen",      64'(sram_gwen), 64'd1);
        check("rst_wen",       64'(sram_wen),  64'h7FFFFFFFFFFFFFF);
        check("rst_a",         64'(sram_a),    64'd0);
        check("rst_d",         64'(sram_d),    64'd0);

        // 1: clear sweep after reset release
        cpurst_b = 1'b1;
        n = 0; strobes = 0; seq_ok = 1'b1;
        while (init_done !== 1'b1 && n < 400) begin
            tick();
            n++;
            if (sram_cen === 1'b0) begin
                if (sram_a !== strobes[7:0] || sram_gwen !== 1'b0 ||
                    sram_wen !== '0 || sram_d !== '0) seq_ok = 1'b0;
                strobes++;
            end
        end
        check("sweep_done_cycle", 64'(n), 64'd257);
        check("sweep_strobes",    64'(strobes), 64'd256);
        check("sweep_sequence",   64'(seq_ok), 64'd1);
        do_read("rd_00_clear", 8'h00, '0);
        do_read("rd_ff_clear", 8'hFF, '0);

        // 2: full write then read back
        do_write("wr_12_full", 8'h12, D1, '1);
        do_read("rd_12_full", 8'h12, D1);

        // 3: partition write enabling only the middle partition
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 8'h12; req_wdata = '1;
        req_wmask = 59'(1) << 57;
        #1;
        check("wr_part_wen", 64'(sram_wen), 64'({1'b1, 29'd0, {29{1'b1}}}));
        check("wr_part_cen", 64'(sram_cen), 64'd0);
        tick();
        req_vld = 1'b0;
        do_read("rd_12_part", 8'h12, EXP3);

        // Zero-mask write still strobes the macro with all WEN bits high
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 8'h40; req_wdata = '1; req_wmask = '0;
        #1;
        check("wr_zmask_cen", 64'(sram_cen), 64'd0);
        check("wr_zmask_wen", 64'(sram_wen), 64'h7FFFFFFFFFFFFFF);
        tick();
        req_vld = 1'b0;

        // Back-to-back reads at one per cycle
        do_write("wr_13", 8'h13, D2, '1);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h12;
        tick();
        check("b2b_first", 64'(rsp_rdata), 64'(EXP3));
        req_addr = 8'h13;
        #1;
        check("b2b_rdy", 64'(req_rdy), 64'd1);
        tick();
        req_vld = 1'b0;
        check("b2b_second_vld", 64'(rsp_vld), 64'd1);
        check("b2b_second",     64'(rsp_rdata), 64'(D2));
        tick();
        check("rsp_vld_clears", 64'(rsp_vld), 64'd0);

        // 4: response stall blocks new requests and keeps data stable
        rsp_rdy = 1'b0;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h12;
        tick();
        req_addr = 8'h13;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_rdy",   64'(req_rdy),   64'd0);
            check("stall_cen",   64'(sram_cen),  64'd1);
            check("stall_rdata", 64'(rsp_rdata), 64'(EXP3));
            tick();
        end
        rsp_rdy = 1'b1;
        #1;
        check("unstall_rdy", 64'(req_rdy), 64'd1);
        tick();
        req_vld = 1'b0;
        check("unstall_vld",  64'(rsp_vld), 64'd1);
        check("unstall_data", 64'(rsp_rdata), 64'(D2));
        tick();

        // 5: init request waits for the stalled response handshake
        rsp_rdy = 1'b0;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h12;
        tick();
        req_vld = 1'b0;
        init_start = 1'b1;
        #1;
        check("init_req_rdy", 64'(req_rdy), 64'd0);
        tick();
        init_start = 1'b0;
        repeat (2) begin
            check("pend_done", 64'(init_done), 64'd1);
            check("pend_vld",  64'(rsp_vld),   64'd1);
            check("pend_cen",  64'(sram_cen),  64'd1);
            tick();
        end
        rsp_rdy = 1'b1;
        tick();
        check("resweep_done0", 64'(init_done), 64'd0);
        check("resweep_vld0",  64'(rsp_vld),   64'd0);
        check("resweep_cen",   64'(sram_cen),  64'd0);
        check("resweep_a0",    64'(sram_a),    64'd0);
        wait_done("resweep_finish", n);
        do_read("rd_12_after_clear", 8'h12, '0);
        do_read("rd_13_after_clear", 8'h13, '0);
        tick();

        // init_start beats a simultaneous request
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h05; init_start = 1'b1;
        #1;
        check("init_wins_rdy", 64'(req_rdy), 64'd0);
        tick();
        init_start = 1'b0; req_vld = 1'b0;
        check("init_wins_vld",  64'(rsp_vld),   64'd0);
        check("init_wins_done", 64'(init_done), 64'd0);
        check("init_wins_a0",   64'(sram_a),    64'd0);

        // init_start during a sweep is ignored
        wait_addr("sweep_reach_50", 8'd50);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check("ignore_init_a", 64'(sram_a), 64'd51);

        // 6: reset mid-sweep restarts from address 0
        wait_addr("sweep_reach_100", 8'd100);
        cpurst_b = 1'b0;
        #1;
        check("midrst_cen", 64'(sram_cen), 64'd1);
        check("midrst_a",   64'(sram_a),   64'd0);
        check("midrst_wen", 64'(sram_wen), 64'h7FFFFFFFFFFFFFF);
        tick();
        check("midrst_done", 64'(init_done), 64'd0);
        check("midrst_rdy",  64'(req_rdy),   64'd0);
        cpurst_b = 1'b1;
        tick();
        check("restart_cen", 64'(sram_cen), 64'd0);
        check("restart_a0",  64'(sram_a),   64'd0);
        wait_done("restart_finish", n);
        check("restart_len", 64'(n), 64'd256);
        do_read("rd_00_final", 8'h00, '0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
